// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared framing constants and state encoding for the tx packet arbiter
package pkt_pkg;

    localparam int WORD_W  = 36;
    localparam int MTY_HI  = 35;
    localparam int MTY_LO  = 34;
    localparam int EOP_BIT = 33;
    localparam int SOP_BIT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_ABORT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/pkt_rr_sel.sv
// rtl/pkt_rr_sel.sv - two-way round-robin pick between packet candidates
module pkt_rr_sel (
    input  logic cand0,
    input  logic cand1,
    input  logic cur_sel,
    output logic grant,
    output logic sel
);

    // On contention the channel not granted last time wins.
    assign grant = cand0 | cand1;
    assign sel   = (cand0 && cand1) ? ~cur_sel : cand1;

endmodule

// File: rtl/tx_pkt_arb.sv
// rtl/tx_pkt_arb.sv - round-robin whole-packet arbiter for two tx FIFOs with stall abort
module tx_pkt_arb
    import pkt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int STALL_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+3:0] ch0_q,
    input  logic              ch0_empty,
    output logic              ch0_rdreq,
    input  logic [DATA_W+3:0] ch1_q,
    input  logic              ch1_empty,
    output logic              ch1_rdreq,
    input  logic              dout_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [1:0]        dout_mty,
    output logic              dout_err,
    output logic              cur_sel,
    output logic              flag_sop_err,
    output logic              flag_stall_err
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_MAX);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [1:0]        mty_q, mty_d;
    logic              err_q, err_d;
    logic              fsop_q, fsop_d;
    logic              fstall_q, fstall_d;
    logic              rd0, rd1;

    logic              cand0, cand1, grant, gsel;
    logic              sel_empty;
    logic [DATA_W+3:0] sel_word;

    assign cand0     = ~ch0_empty & ch0_q[SOP_BIT];
    assign cand1     = ~ch1_empty & ch1_q[SOP_BIT];
    assign sel_empty = sel_q ? ch1_empty : ch0_empty;
    assign sel_word  = sel_q ? ch1_q : ch0_q;

    pkt_rr_sel u_rr (
        .cand0   (cand0),
        .cand1   (cand1),
        .cur_sel (cur_sel_q),
        .grant   (grant),
        .sel     (gsel)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cur_sel_d   = cur_sel_q;
        cnt_stall_d = cnt_stall_q;
        rd0         = 1'b0;
        rd1         = 1'b0;
        dout_d      = '0;
        vld_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        mty_d       = 2'd0;
        err_d       = 1'b0;
        fsop_d      = 1'b0;
        fstall_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    sel_d       = gsel;
                    cur_sel_d   = gsel;
                    cnt_stall_d = '0;
                    state_d     = ST_SEND;
                end else if (!ch0_empty) begin
                    rd0    = 1'b1;
                    fsop_d = 1'b1;
                end else if (!ch1_empty) begin
                    rd1    = 1'b1;
                    fsop_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (!sel_empty) begin
                    // A ready-blocked but non-empty FIFO is not a stall.
                    if (dout_rdy) begin
                        rd0         = ~sel_q;
                        rd1         = sel_q;
                        cnt_stall_d = '0;
                        vld_d       = 1'b1;
                        dout_d      = sel_word[DATA_W-1:0];
                        sop_d       = sel_word[SOP_BIT];
                        eop_d       = sel_word[EOP_BIT];
                        mty_d       = sel_word[MTY_HI:MTY_LO];
                        if (sel_word[EOP_BIT]) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (cnt_stall_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                end else if (cnt_stall_q != CNT_SAT) begin
                    cnt_stall_d = cnt_stall_q + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                if (dout_rdy) begin
                    vld_d    = 1'b1;
                    eop_d    = 1'b1;
                    err_d    = 1'b1;
                    fstall_d = 1'b1;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!sel_empty) begin
                    // A fresh sop means the stalled packet never ended; leave it for IDLE.
                    if (sel_word[SOP_BIT]) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd0 = ~sel_q;
                        rd1 = sel_q;
                        if (sel_word[EOP_BIT]) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            cur_sel_q   <= 1'b1;
            cnt_stall_q <= '0;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            mty_q       <= 2'd0;
            err_q       <= 1'b0;
            fsop_q      <= 1'b0;
            fstall_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cur_sel_q   <= cur_sel_d;
            cnt_stall_q <= cnt_stall_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            mty_q       <= mty_d;
            err_q       <= err_d;
            fsop_q      <= fsop_d;
            fstall_q    <= fstall_d;
        end
    end

    // Pops are suppressed during reset so the external FIFOs are left untouched.
    assign ch0_rdreq      = rd0 & ~rst_n;
    assign ch1_rdreq      = rd1 & ~rst_n;
    assign dout           = dout_q;
    assign dout_vld       = vld_q;
    assign dout_sop       = sop_q;
    assign dout_eop       = eop_q;
    assign dout_mty       = mty_q;
    assign dout_err       = err_q;
    assign cur_sel        = cur_sel_q;
    assign flag_sop_err   = fsop_q;
    assign flag_stall_err = fstall_q;

endmodule

// File: tb/tb_tx_pkt_arb.sv
// tb/tb_tx_pkt_arb.sv - scoreboard bench for tx_pkt_arb with FIFO and packet-order models
module tb_tx_pkt_arb;
    import pkt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] ch0_q, ch1_q;
    logic        ch0_empty, ch1_empty, ch0_rdreq, ch1_rdreq;
    logic        dout_rdy;
    logic [31:0] dout;
    logic        dout_vld, dout_sop, dout_eop, dout_err, cur_sel;
    logic [1:0]  dout_mty;
    logic        flag_sop_err, flag_stall_err;

    tx_pkt_arb #(.DATA_W(32), .STALL_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_q(ch0_q), .ch0_empty(ch0_empty), .ch0_rdreq(ch0_rdreq),
        .ch1_q(ch1_q), .ch1_empty(ch1_empty), .ch1_rdreq(ch1_rdreq),
        .dout_rdy(dout_rdy), .dout(dout), .dout_vld(dout_vld),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_mty(dout_mty),
        .dout_err(dout_err), .cur_sel(cur_sel),
        .flag_sop_err(flag_sop_err), .flag_stall_err(flag_stall_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  mty;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [35:0] q0[$], q1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lowrun   = 0;
    bit          last_ch;
    bit          stop_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] mkw(input logic [1:0] m, input logic e, input logic s,
                                        input logic [31:0] d);
        return {m, e, s, d};
    endfunction

    task automatic refresh();
        ch0_empty = (q0.size() == 0);
        ch1_empty = (q1.size() == 0);
        ch0_q     = ch0_empty ? 36'd0 : q0[0];
        ch1_q     = ch1_empty ? 36'd0 : q1[0];
    endtask

    task automatic push_word(input bit ch, input logic [35:0] w, input bit expect_out);
        if (ch) q1.push_back(w);
        else    q0.push_back(w);
        if (expect_out)
            sb.push_back('{data: w[31:0], sop: w[SOP_BIT], eop: w[EOP_BIT],
                           mty: w[MTY_HI:MTY_LO], err: 1'b0});
    endtask

    task automatic push_pkt(input bit ch, input int len);
        logic [1:0] m;
        m = 2'($urandom_range(0, 3));
        for (int j = 0; j < len; j++)
            push_word(ch, mkw((j == len - 1) ? m : 2'd0, j == len - 1, j == 0, $urandom), 1'b1);
        last_ch = ch;
        refresh();
    endtask

    // Packet-level round robin: with both channels loaded, grants alternate.
    task automatic push_rr(input int n0, input int n1, input int maxlen);
        int a, b;
        bit c;
        a = n0;
        b = n1;
        while (a > 0 || b > 0) begin
            c = (a > 0 && b > 0) ? ~last_ch : (a == 0);
            push_pkt(c, $urandom_range(1, maxlen));
            if (c) b--;
            else   a--;
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
        end
        check(name, 64'(sb.size() + q0.size() + q1.size()), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input string name, input int n, input int budget);
        int seen;
        seen = 0;
        for (int k = 0; k < budget && seen < n; k++) begin
            @(negedge clk);
            if (dout_vld) seen++;
        end
        check(name, 64'(seen), 64'(n));
    endtask

    // FIFO model: pops decided at the negedge take effect just after the next edge.
    initial begin : fifo_drv
        bit p0, p1;
        forever begin
            @(negedge clk);
            p0 = ch0_rdreq;
            p1 = ch1_rdreq;
            @(posedge clk);
            #1;
            if (p0 && q0.size() > 0) void'(q0.pop_front());
            if (p1 && q1.size() > 0) void'(q1.pop_front());
            refresh();
        end
    end

    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            check("one_rdreq", 64'(ch0_rdreq & ch1_rdreq), 64'd0);
            check("pop_when_empty", 64'({ch0_rdreq & ch0_empty, ch1_rdreq & ch1_empty}), 64'd0);
            if (dout_vld) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got dout=%h sop=%b eop=%b err=%b, no word expected",
                             dout, dout_sop, dout_eop, dout_err);
                end else begin
                    mon_e = sb.pop_front();
                    check("word", 64'({dout, dout_sop, dout_eop, dout_mty, dout_err}),
                          64'({mon_e.data, mon_e.sop, mon_e.eop, mon_e.mty, mon_e.err}));
                end
            end else begin
                check("idle_zero", 64'({dout, dout_mty, dout_sop, dout_eop, dout_err}), 64'd0);
            end
            if (!dout_rdy) begin
                if (dout_vld) lowrun++;
                check("vld_after_rdy_low", 64'(lowrun > 1), 64'd0);
            end else begin
                lowrun = 0;
            end
        end
    end

    task automatic run_abort(input bit end_sop);
        bit found;
        int gap;
        @(posedge clk);
        #1;
        push_word(1'b1, mkw(2'd0, 1'b0, 1'b1, $urandom), 1'b1);
        sb.push_back('{data: 32'd0, sop: 1'b0, eop: 1'b1, mty: 2'd0, err: 1'b1});
        last_ch = 1'b1;
        refresh();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (dout_vld && dout_sop) found = 1'b1;
        end
        check("abort_sop_seen", 64'(found), 64'd1);
        gap = 101;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (dout_vld) begin
                gap = k;
                break;
            end
        end
        check("abort_gap", 64'(gap), 64'd65);
        check("stall_flag_on", 64'({flag_stall_err, dout_err}), 64'b11);
        @(negedge clk);
        check("stall_flag_off", 64'(flag_stall_err), 64'd0);
        @(posedge clk);
        #1;
        push_word(1'b1, mkw(2'd0, 1'b0, 1'b0, $urandom), 1'b0);
        if (end_sop) push_pkt(1'b1, 2);
        else         push_word(1'b1, mkw(2'($urandom_range(0, 3)), 1'b1, 1'b0, $urandom), 1'b0);
        refresh();
        drain("abort_flush_drain", 100);
        push_pkt(1'b0, 3);
        drain("after_abort_drain", 100);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [5:0] vv, rr;
        logic       s2, e4;
        logic [1:0] m4;
        int         pulses;

        rst_n    = 1'b1;
        dout_rdy = 1'b1;
        last_ch  = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({dout_vld, dout, dout_sop, dout_eop, dout_mty, dout_err,
                                    flag_sop_err, flag_stall_err, ch0_rdreq, ch1_rdreq}), 64'd0);
        check("reset_cur_sel", 64'(cur_sel), 64'd1);
        check("reset_cnt", 64'(dut.cnt_stall_q), 64'd0);
        @(posedge clk);
        #1;

        // Two 2-word packets per channel: ch0, ch1, ch0, ch1.
        for (int i = 0; i < 4; i++) begin
            push_word(i[0], mkw(2'd0, 1'b0, 1'b1, $urandom), 1'b1);
            push_word(i[0], mkw(2'(i), 1'b1, 1'b0, $urandom), 1'b1);
        end
        last_ch = 1'b1;
        refresh();
        drain("rr_drain", 100);
        check("rr_cur_sel", 64'(cur_sel), 64'(last_ch));

        // Single 3-word packet on ch0: cycle-exact latency.
        push_word(1'b0, mkw(2'd0, 1'b0, 1'b1, 32'hA000_0000), 1'b1);
        push_word(1'b0, mkw(2'd0, 1'b0, 1'b0, 32'hA000_0001), 1'b1);
        push_word(1'b0, mkw(2'd2, 1'b1, 1'b0, 32'hA000_0002), 1'b1);
        last_ch = 1'b0;
        refresh();
        s2 = 1'b0;
        e4 = 1'b0;
        m4 = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vv[k] = dout_vld;
            rr[k] = ch0_rdreq;
            if (k == 2) s2 = dout_sop;
            if (k == 4) begin
                e4 = dout_eop;
                m4 = dout_mty;
            end
        end
        check("pktA_vld_timing", 64'(vv), 64'b011100);
        check("pktA_rdreq_timing", 64'(rr), 64'b001110);
        check("pktA_sop_eop_mty", 64'({s2, e4, m4}), 64'b1110);
        check("pktA_cur_sel", 64'(cur_sel), 64'd0);
        drain("pktA_drain", 20);

        // Backpressure window mid-packet.
        push_pkt(1'b0, 6);
        wait_vld("bp_first_words", 2, 20);
        @(posedge clk);
        #1;
        dout_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_no_rdreq", 64'({ch0_rdreq, ch1_rdreq}), 64'd0);
            check("bp_cnt_zero", 64'(dut.cnt_stall_q), 64'd0);
        end
        @(posedge clk);
        #1;
        dout_rdy = 1'b1;
        drain("bp_drain", 50);

        // Stray non-sop head in IDLE.
        push_word(1'b0, mkw(2'd1, 1'b1, 1'b0, $urandom), 1'b0);
        refresh();
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (flag_sop_err) pulses++;
        end
        check("sop_err_pulses", 64'(pulses), 64'd1);
        @(posedge clk);
        #1;
        push_pkt(1'b0, 3);
        drain("sop_err_drain", 50);

        run_abort(1'b0);
        run_abort(1'b1);

        // Randomised traffic with random backpressure.
        stop_rdy = 1'b0;
        fork
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    if (stop_rdy) break;
                    dout_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int r = 0; r < 8; r++) begin
            push_rr($urandom_range(0, 3), $urandom_range(0, 3), 5);
            drain("rand_drain", 500);
            check("rand_cur_sel", 64'(cur_sel), 64'(last_ch));
        end
        stop_rdy = 1'b1;
        @(posedge clk);
        #2;
        dout_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-packet, then contention must go to ch0.
        push_pkt(1'b0, 5);
        wait_vld("rst_first_words", 2, 20);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        refresh();
        @(negedge clk);
        check("rst_mid_outputs", 64'({dout_vld, dout, dout_sop, dout_eop, dout_mty, dout_err,
                                      flag_sop_err, flag_stall_err}), 64'd0);
        check("rst_mid_cur_sel", 64'(cur_sel), 64'd1);
        check("rst_mid_state", 64'(dut.state_q), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        last_ch = 1'b1;
        push_rr(1, 1, 4);
        drain("rst_rr_drain", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
